// File: rtl/key_cmd_pkg.sv
// Shared constants for the keyboard command controller:
// scan codes, command encodings and the decode helper.
package key_cmd_pkg;

    localparam int CMD_W   = 3;
    localparam int NUM_CMD = 5;

    localparam logic [CMD_W-1:0] CMD_UP      = 3'd0;
    localparam logic [CMD_W-1:0] CMD_DOWN    = 3'd1;
    localparam logic [CMD_W-1:0] CMD_LEFT    = 3'd2;
    localparam logic [CMD_W-1:0] CMD_RIGHT   = 3'd3;
    localparam logic [CMD_W-1:0] CMD_RESTART = 3'd4;

    localparam logic [7:0] SC_E_UP    = 8'h75;
    localparam logic [7:0] SC_E_DOWN  = 8'h72;
    localparam logic [7:0] SC_E_LEFT  = 8'h6B;
    localparam logic [7:0] SC_E_RIGHT = 8'h74;
    localparam logic [7:0] SC_UP      = 8'h1D;
    localparam logic [7:0] SC_DOWN    = 8'h1B;
    localparam logic [7:0] SC_LEFT    = 8'h1C;
    localparam logic [7:0] SC_RIGHT   = 8'h23;
    localparam logic [7:0] SC_RESTART = 8'h2D;

    typedef struct packed {
        logic             hit;
        logic [CMD_W-1:0] cmd;
    } dec_t;

    // Arrow keys exist as extended codes and as WASD; restart is plain R.
    function automatic dec_t decode_key(input logic ext,
                                        input logic [7:0] code);
        dec_t d;
        d.hit = 1'b1;
        d.cmd = CMD_UP;
        unique case (1'b1)
            (ext && code == SC_E_UP) || (!ext && code == SC_UP):
                d.cmd = CMD_UP;
            (ext && code == SC_E_DOWN) || (!ext && code == SC_DOWN):
                d.cmd = CMD_DOWN;
            (ext && code == SC_E_LEFT) || (!ext && code == SC_LEFT):
                d.cmd = CMD_LEFT;
            (ext && code == SC_E_RIGHT) || (!ext && code == SC_RIGHT):
                d.cmd = CMD_RIGHT;
            (!ext && code == SC_RESTART):
                d.cmd = CMD_RESTART;
            default:
                d.hit = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Command queue: first-word fall-through with a registered head,
// accepts a push when full if the head leaves in the same cycle.
module cmd_fifo
    import key_cmd_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [CMD_W-1:0]         din,
    input  logic                     pop,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic [CMD_W-1:0]         head,
    output logic                     head_valid
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];
    localparam logic [AW:0] ONE_LVL  = (AW+1)'(1);

    logic [CMD_W-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_nxt;
    logic [AW:0]      cnt;
    logic [AW:0]      cnt_nxt;
    logic             pop_ok;
    logic             push_ok;

    assign full    = (cnt == FULL_LVL);
    assign empty   = (cnt == '0);
    assign level   = cnt;
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign rd_nxt  = rd_ptr + AW'(1);

    // Occupancy after this cycle's push/pop.
    always_comb begin
        cnt_nxt = cnt;
        if (push_ok && !pop_ok)
            cnt_nxt = cnt + ONE_LVL;
        else if (pop_ok && !push_ok)
            cnt_nxt = cnt - ONE_LVL;
    end

    // Storage; the slot being popped may be reused on a full push.
    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= din;
    end

    // Pointers, level and the registered head word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            cnt        <= '0;
            head       <= '0;
            head_valid <= 1'b0;
        end else begin
            cnt        <= cnt_nxt;
            head_valid <= (cnt_nxt != '0);
            if (push_ok)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok) begin
                rd_ptr <= rd_nxt;
                if (cnt == ONE_LVL) begin
                    if (push_ok)
                        head <= din;
                end else begin
                    head <= mem[rd_nxt];
                end
            end else if (push_ok && empty) begin
                head <= din;
            end
        end
    end

endmodule

// File: rtl/key_cmd_ctrl.sv
// Keyboard event to game command translator with a drop counter.
// Define KEY_REPEAT_FILTER_EN to suppress typematic repeats.
module key_cmd_ctrl
    import key_cmd_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int DROP_CNT_W = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [9:0]                  key_data,
    input  logic                        key_ready,
    output logic                        cmd_valid,
    output logic [CMD_W-1:0]            cmd_code,
    input  logic                        cmd_ready,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic [DROP_CNT_W-1:0]       drop_cnt
);

    dec_t dec;
    logic brk;
    logic req;
    logic full;
    logic empty;
    logic drop;

    assign dec = decode_key(key_data[9], key_data[7:0]);
    assign brk = key_data[8];

`ifdef KEY_REPEAT_FILTER_EN
    logic [NUM_CMD-1:0] held;

    assign req = key_ready && dec.hit && !brk && !held[dec.cmd];

    // Make marks the command held, break releases it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            held <= '0;
        else if (key_ready && dec.hit)
            held[dec.cmd] <= !brk;
    end
`else
    assign req = key_ready && dec.hit && !brk;
`endif

    assign drop = req && full && !(cmd_ready && !empty);

    cmd_fifo #(
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (req),
        .din        (dec.cmd),
        .pop        (cmd_ready),
        .full       (full),
        .empty      (empty),
        .level      (fifo_level),
        .head       (cmd_code),
        .head_valid (cmd_valid)
    );

    // Saturating count of commands lost to a full queue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            drop_cnt <= '0;
        else if (drop && drop_cnt != '1)
            drop_cnt <= drop_cnt + DROP_CNT_W'(1);
    end

endmodule

// File: tb/tb_key_cmd_ctrl.sv
// Directed bench for key_cmd_ctrl; expectations adapt to
// KEY_REPEAT_FILTER_EN where the filter changes behaviour.
module tb_key_cmd_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] key_data;
    logic       key_ready;
    logic       cmd_valid;
    logic [2:0] cmd_code;
    logic       cmd_ready;
    logic [2:0] fifo_level;
    logic [7:0] drop_cnt;

    int checks = 0;
    int errors = 0;
    int log_q[$];

    key_cmd_ctrl #(
        .FIFO_DEPTH (4),
        .DROP_CNT_W (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key_data   (key_data),
        .key_ready  (key_ready),
        .cmd_valid  (cmd_valid),
        .cmd_code   (cmd_code),
        .cmd_ready  (cmd_ready),
        .fifo_level (fifo_level),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    // Record every accepted command in order.
    always @(posedge clk) begin
        if (!rst && cmd_valid && cmd_ready)
            log_q.push_back(int'(cmd_code));
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic strobe(input logic [9:0] d);
        @(negedge clk);
        key_data  = d;
        key_ready = 1'b1;
        @(negedge clk);
        key_ready = 1'b0;
        key_data  = 10'h3FF;
    endtask

    task automatic release_all();
        strobe(10'h11D);
        strobe(10'h11B);
        strobe(10'h11C);
        strobe(10'h123);
        strobe(10'h12D);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        cmd_ready = 1'b1;
        while (fifo_level != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        cmd_ready = 1'b0;
        chk(tag, 32'(n < 20), 32'd1);
    endtask

    initial begin
        int exp_rpt;
        rst       = 1'b1;
        key_data  = 10'h000;
        key_ready = 1'b0;
        cmd_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(cmd_valid), 0);
        chk("rst_code", 32'(cmd_code), 0);
        chk("rst_level", 32'(fifo_level), 0);
        chk("rst_drop", 32'(drop_cnt), 0);
        rst = 1'b0;

        strobe(10'h275);
        chk("up_valid", 32'(cmd_valid), 1);
        chk("up_code", 32'(cmd_code), 0);
        chk("up_level", 32'(fifo_level), 1);
        @(negedge clk);
        chk("up_hold", 32'(cmd_code), 0);
        drain("up_drain");
        chk("up_empty", 32'(cmd_valid), 0);

        log_q.delete();
        cmd_ready = 1'b1;
        strobe(10'h01C);
        chk("seq_left", 32'(cmd_code), 2);
        strobe(10'h023);
        chk("seq_right", 32'(cmd_code), 3);
        strobe(10'h01B);
        chk("seq_down", 32'(cmd_code), 1);
        @(negedge clk);
        cmd_ready = 1'b0;
        chk("seq_level", 32'(fifo_level), 0);
        chk("seq_count", 32'(log_q.size()), 3);
        if (log_q.size() == 3) begin
            chk("seq_ord0", 32'(log_q[0]), 2);
            chk("seq_ord1", 32'(log_q[1]), 3);
            chk("seq_ord2", 32'(log_q[2]), 1);
        end
        release_all();

        strobe(10'h12D);
        chk("brk_level", 32'(fifo_level), 0);
        chk("brk_valid", 32'(cmd_valid), 0);
        strobe(10'h05A);
        chk("unm_level", 32'(fifo_level), 0);
        chk("unm_drop", 32'(drop_cnt), 0);
        @(negedge clk);
        key_data = 10'h01D;
        repeat (2) @(negedge clk);
        key_data = 10'h3FF;
        chk("noqual_lvl", 32'(fifo_level), 0);

        strobe(10'h01D);
        strobe(10'h01B);
        strobe(10'h01C);
        strobe(10'h023);
        chk("fill_level", 32'(fifo_level), 4);
        chk("fill_drop", 32'(drop_cnt), 0);
        strobe(10'h02D);
        strobe(10'h11D);
        strobe(10'h01D);
        chk("full_level", 32'(fifo_level), 4);
        chk("full_drop", 32'(drop_cnt), 2);
        chk("full_head", 32'(cmd_code), 0);
        strobe(10'h11B);
        log_q.delete();
        @(negedge clk);
        key_data  = 10'h01B;
        key_ready = 1'b1;
        cmd_ready = 1'b1;
        @(negedge clk);
        key_ready = 1'b0;
        cmd_ready = 1'b0;
        chk("fp_level", 32'(fifo_level), 4);
        chk("fp_drop", 32'(drop_cnt), 2);
        chk("fp_head", 32'(cmd_code), 1);
        drain("fp_drain");
        chk("fp_count", 32'(log_q.size()), 5);
        if (log_q.size() == 5) begin
            chk("fp_ord0", 32'(log_q[0]), 0);
            chk("fp_ord1", 32'(log_q[1]), 1);
            chk("fp_ord2", 32'(log_q[2]), 2);
            chk("fp_ord3", 32'(log_q[3]), 3);
            chk("fp_ord4", 32'(log_q[4]), 1);
        end
        release_all();

`ifdef KEY_REPEAT_FILTER_EN
        exp_rpt = 2;
`else
        exp_rpt = 4;
`endif
        log_q.delete();
        strobe(10'h274);
        strobe(10'h274);
        strobe(10'h274);
        strobe(10'h374);
        strobe(10'h274);
        chk("rpt_level", 32'(fifo_level), 32'(exp_rpt));
        chk("rpt_drop", 32'(drop_cnt), 2);
        drain("rpt_drain");
        chk("rpt_count", 32'(log_q.size()), 32'(exp_rpt));
        release_all();

        strobe(10'h01D);
        strobe(10'h01B);
        strobe(10'h01C);
        strobe(10'h023);
        for (int i = 0; i < 260; i++) begin
            strobe(10'h11D);
            strobe(10'h01D);
        end
        chk("sat_drop", 32'(drop_cnt), 255);
        chk("sat_level", 32'(fifo_level), 4);

        @(negedge clk);
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
        chk("pre_rst_lvl", 32'(fifo_level), 3);
        rst = 1'b1;
        #2;
        chk("mid_rst_valid", 32'(cmd_valid), 0);
        chk("mid_rst_code", 32'(cmd_code), 0);
        chk("mid_rst_level", 32'(fifo_level), 0);
        chk("mid_rst_drop", 32'(drop_cnt), 0);
        @(negedge clk);
        rst = 1'b0;
        strobe(10'h02D);
        chk("post_valid", 32'(cmd_valid), 1);
        chk("post_code", 32'(cmd_code), 4);
        chk("post_level", 32'(fifo_level), 1);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
